// File: rtl/gate_vector_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_vector_checker
// Purpose  : Exhaustive stimulus generator and response checker for an
//            N-input combinational gate. Sweeps every input combination,
//            holds each for HOLD cycles, samples the DUT output on the last
//            hold cycle and compares it against a reduction reference.
// Ports    : clk             - clock, rising edge
//            rst_n           - synchronous active-low reset
//            start           - begin a sweep (honoured in IDLE or DONE only)
//            dut_y           - DUT output under test
//            stim            - DUT input vector
//            busy            - sweep in progress
//            done            - sweep finished, results valid
//            pass            - no failing vectors (valid with done)
//            mismatch        - one-cycle pulse after a failing sample
//            err_count       - failing vector count, saturating
//            first_err_vec   - stim value of the first failure
//            first_err_valid - first_err_vec holds a captured value
// Revision : 1.0 - initial release
// ============================================================================
module gate_vector_checker #(
  parameter int WIDTH = 2,
  parameter int HOLD  = 10,
  parameter int MODE  = 0,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_y,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_err_vec,
  output logic             first_err_valid
);

  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HC_W-1:0]  c_hold_last = HC_W'(HOLD - 1);
  localparam logic [WIDTH-1:0] c_stim_max  = '1;
  localparam logic [ERR_W-1:0] c_err_max   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state;
  logic [HC_W-1:0]  r_hold_cnt, w_hold_cnt;
  logic [WIDTH-1:0] r_stim, w_stim;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_pass, w_pass;
  logic             r_mismatch, w_mismatch;
  logic [ERR_W-1:0] r_err, w_err;
  logic [WIDTH-1:0] r_fev, w_fev;
  logic             r_fev_valid, w_fev_valid;

  logic w_expected;
  logic w_fail;

  // Reference function; reserved modes fall back to AND-reduce.
  always_comb begin
    case (MODE)
      1:       w_expected = |r_stim;
      2:       w_expected = ^r_stim;
      3:       w_expected = ~&r_stim;
      default: w_expected = &r_stim;
    endcase
  end

  // Case inequality so an X on dut_y counts as a failure rather than
  // silently falling through an if.
  assign w_fail = (dut_y !== w_expected);

  always_comb begin
    w_state     = r_state;
    w_hold_cnt  = r_hold_cnt;
    w_stim      = r_stim;
    w_busy      = r_busy;
    w_done      = r_done;
    w_pass      = r_pass;
    w_mismatch  = 1'b0;
    w_err       = r_err;
    w_fev       = r_fev;
    w_fev_valid = r_fev_valid;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state     = ST_RUN;
          w_hold_cnt  = '0;
          w_stim      = '0;
          w_busy      = 1'b1;
          w_done      = 1'b0;
          w_pass      = 1'b0;
          w_err       = '0;
          w_fev       = '0;
          w_fev_valid = 1'b0;
        end
      end

      ST_RUN: begin
        w_hold_cnt = r_hold_cnt + HC_W'(1);
        if (r_hold_cnt == c_hold_last) begin
          w_hold_cnt = '0;
          if (w_fail) begin
            w_mismatch = 1'b1;
            if (r_err != c_err_max) begin
              w_err = r_err + ERR_W'(1);
            end
            if (!r_fev_valid) begin
              w_fev       = r_stim;
              w_fev_valid = 1'b1;
            end
          end
          if (r_stim != c_stim_max) begin
            w_stim = r_stim + WIDTH'(1);
          end else begin
            // Verdict uses the count including this final sample.
            w_state = ST_DONE;
            w_stim  = '0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_pass  = (w_err == '0);
          end
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hold_cnt  <= '0;
      r_stim      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_mismatch  <= 1'b0;
      r_err       <= '0;
      r_fev       <= '0;
      r_fev_valid <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_hold_cnt  <= w_hold_cnt;
      r_stim      <= w_stim;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_pass      <= w_pass;
      r_mismatch  <= w_mismatch;
      r_err       <= w_err;
      r_fev       <= w_fev;
      r_fev_valid <= w_fev_valid;
    end
  end

  assign stim            = r_stim;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign mismatch        = r_mismatch;
  assign err_count       = r_err;
  assign first_err_vec   = r_fev;
  assign first_err_valid = r_fev_valid;

endmodule
`default_nettype wire

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
Synthesizable exhaustive-vector stimulus generator and response checker for an N-input combinational gate DUT. It sweeps all 2^WIDTH input combinations and holds each for HOLD cycles. It compares the DUT output against a parametrised reference function and reports error count, first failing vector and pass/fail. It is the self-checking, parametrised successor to the hand-written two-input gate bench, and it is instantiated alongside the DUT in simulation or on-board bring-up.

Parameters:
WIDTH, 2, number of DUT inputs (1..16); vectors swept = 2^WIDTH
HOLD, 10, clock cycles each vector is held before sampling (>=1)
MODE, 0, reference function: 0 AND-reduce, 1 OR-reduce, 2 XOR-reduce, 3 NAND-reduce; 4..7 reserved, behave as AND
ERR_W, 16, width of error counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE or DONE
dut_y  input  1  DUT output under test
stim  output  WIDTH  DUT input vector
busy  output  1  high while sweep in progress
done  output  1  high in DONE state until next start or reset
pass  output  1  valid when done=1; 1 iff err_count==0
mismatch  output  1  one-cycle pulse after a failing sample
err_count  output  ERR_W  failing vectors, saturating at 2^ERR_W-1
first_err_vec  output  WIDTH  stim value of first failure
first_err_valid  output  1  first_err_vec holds a captured value

Behaviour:
- Reset (rst_n=0 at a rising edge), including mid-sweep: the next cycle shows state=IDLE, stim=0, busy=0, done=0, pass=0, mismatch=0, err_count=0, first_err_vec=0, first_err_valid=0, hold counter=0. No partial results survive.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE: on start=1 at an edge, go to RUN, stim=0, hold_cnt=0, busy=1. Counters and first-error capture are cleared on the same edge.
- RUN: hold_cnt increments each cycle.
  - At the edge where hold_cnt==HOLD-1, the sample is taken: compare dut_y against expected(stim).
  - On mismatch: err_count+1 (saturating); mismatch=1 for the following cycle only; if first_err_valid=0, capture first_err_vec=stim and set first_err_valid=1.
  - On the same edge, hold_cnt resets to 0. If stim != 2^WIDTH-1, stim increments. Otherwise go to DONE: busy=0, done=1, stim=0, pass=(final err_count==0). The final err_count includes the last sample.
- Sweep duration: exactly 2^WIDTH*HOLD cycles with busy=1. HOLD=1 samples every cycle.
- start is ignored while busy=1.
- DONE: outputs hold until start=1. start=1 restarts exactly as from IDLE: done drops, busy rises the next cycle, results are cleared.
- Sampling occurs HOLD-1 cycles after stim changes, which lets the DUT settle (zero-delay for HOLD=1). dut_y must not be X at sample time; X compares as mismatch.
- mismatch can pulse in the first DONE cycle if the last vector fails.
- Saturation: err_count stops at its max; first-error capture is unaffected.

Test Plan:
1. WIDTH=2, HOLD=10, MODE=0, correct AND DUT, one-cycle start -> busy high 40 cycles; stim 0,1,2,3 each held 10 cycles; then done=1, pass=1, err_count=0, first_err_valid=0, stim=0.
2. Same config, dut_y stuck at 0 -> single mismatch pulse right after the sample of vector 3; err_count=1, first_err_vec=3, first_err_valid=1, pass=0.
3. WIDTH=3, HOLD=1, MODE=2, DUT = inverted XOR -> 8 busy cycles, 8 consecutive mismatch pulses; err_count=8, first_err_vec=0, pass=0.
4. Assert rst_n=0 for one cycle while stim=2 in RUN -> next cycle all outputs at reset values. A following start restarts at stim=0 and completes normally, giving the same results as scenario 1.
5. Hold start=1 continuously with a correct DUT -> no restart during RUN. DONE lasts exactly one cycle before an immediate restart. Second sweep results match the first.
6. ERR_W=2, WIDTH=3, MODE=0, dut_y = ~expected -> err_count saturates at 3; 8 mismatch pulses still occur; first_err_vec=0.
